program_run_controller: RTL
===========================

Name: program_run_controller

Overview:
Sequences one program run on the ARM core. It streams a program image into the unified instruction/data memory and initialises SP and LR in the register file. It then releases the CPU from reset, counts execution cycles, and detects termination when the PC reaches the return address in LR. It sits above Top and owns the CPU reset, a memory write port and a register-file init port.

Parameters:
ADDR_WIDTH, 20, word-address width of the memory; 2^20 words = 4 MB.
SP_INIT, 32'h003F_FFFC, value written to R13; LR gets SP_INIT+4.
MAX_CYCLES, 1000000, run-cycle budget before timeout.
CYC_WIDTH, 32, width of cycle_count.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high.
start  in  1  begin load+run; sampled in IDLE/DONE/FAULT only.
abort  in  1  return to IDLE from any state.
load_valid  in  1  program word valid.
load_ready  out  1  controller accepts word.
load_data  in  32  program word.
load_last  in  1  final word of image.
mem_we  out  1  memory write strobe.
mem_addr  out  32  byte address; word index * 4.
mem_wdata  out  32  memory write data.
reg_we  out  1  register-file init write.
reg_addr  out  4  register index.
reg_wdata  out  32  register write data.
cpu_reset  out  1  active-high reset to the core.
cpu_pc  in  32  current core PC.
busy  out  1  state is LOAD..RUN.
done  out  1  run terminated normally; sticky.
fault  out  1  run failed; sticky.
fault_code  out  2  0 none, 1 image overflow, 2 timeout.
cycle_count  out  CYC_WIDTH  cycles with cpu_reset low in current run.

Behaviour:
- Reset (async): state=IDLE. All outputs 0 except cpu_reset=1. Word index=0.
- All outputs are registered. States: IDLE, LOAD, INIT_SP, INIT_LR, RUN, DONE, FAULT.
- IDLE/DONE/FAULT + start: go to LOAD. Clear done, fault, fault_code, cycle_count and index. load_ready=1 from the first LOAD cycle.
- LOAD: a transfer occurs when load_valid and load_ready are both high.
  - The following cycle: mem_we=1, mem_addr=index*4, mem_wdata=data. One-cycle latency. Otherwise mem_we=0.
  - index increments per transfer. Back-to-back transfers are allowed at one word per cycle.
  - Transfer with load_last: load_ready=0 next cycle, go to INIT_SP.
  - Transfer at index 2^ADDR_WIDTH-1 without load_last: the word is still written. Go to FAULT, fault_code=1, load_ready=0.
  - Transfer at that index with load_last: normal path.
- INIT_SP: one cycle, reg_we=1, reg_addr=13, reg_wdata=SP_INIT.
- INIT_LR: one cycle, reg_we=1, reg_addr=14, reg_wdata=SP_INIT+4. Then go to RUN.
- RUN: cpu_reset=0 on the first RUN cycle; reset was held high through LOAD/INIT.
  - cycle_count increments every RUN cycle and saturates.
  - If cpu_pc == SP_INIT+4: go to DONE, done=1, cpu_reset=1 next cycle.
  - If cycle_count == MAX_CYCLES-1 with no halt: go to FAULT, fault_code=2, cpu_reset=1.
  - Halt and timeout in the same cycle: DONE wins.
- DONE/FAULT: cpu_reset=1. cycle_count, done and fault are held.
- start in LOAD..RUN is ignored.
- abort in any non-IDLE state: next cycle IDLE, cpu_reset=1, load_ready=0, mem_we=0, reg_we=0. done/fault are cleared. A pending write is dropped.
- Precedence: abort beats start. Reset beats everything.
- busy=1 iff state ∈ {LOAD, INIT_SP, INIT_LR, RUN}.

Test Plan:
- Reset, start, stream 3 words (E3A00005, E2801001, E12FFF1E; last on the 3rd) -> mem_we pulses at byte addresses 0, 4, 8 with matching data, each one cycle after its handshake. Then reg writes R13=003FFFFC and R14=00400000. Then cpu_reset falls.
- In RUN, drive cpu_pc=0,4,8 then 00400000 on the 4th RUN cycle -> done=1, cycle_count=4, cpu_reset=1 next cycle, fault=0.
- load_valid toggling with gaps -> only handshaken words are written, with the index contiguous.
- MAX_CYCLES=10, cpu_pc never reaches 00400000 -> fault=1, fault_code=2, cycle_count=10 (counting the boundary cycle as the 10th), cpu_reset=1.
- ADDR_WIDTH=2, 5 words with no last -> 4 writes (addresses 0..C), then fault_code=1 after the 4th handshake. The 5th word is never accepted.
- abort asserted mid-LOAD and mid-RUN, and asserted together with start -> IDLE next cycle, cpu_reset=1, no further mem_we/reg_we, done=fault=0. Async reset mid-RUN -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/program_run_controller_if.sv
// Host/memory/register-file/core signal bundle for one program run controller.
// The host (master) drives the image stream, start/abort and the core PC; the controller (slave) drives the rest.
interface program_run_controller_if #(
    parameter int CYC_WIDTH = 32
);
    logic                 start;
    logic                 abort;
    logic                 load_valid;
    logic                 load_ready;
    logic [31:0]          load_data;
    logic                 load_last;
    logic                 mem_we;
    logic [31:0]          mem_addr;
    logic [31:0]          mem_wdata;
    logic                 reg_we;
    logic [3:0]           reg_addr;
    logic [31:0]          reg_wdata;
    logic                 cpu_reset;
    logic [31:0]          cpu_pc;
    logic                 busy;
    logic                 done;
    logic                 fault;
    logic [1:0]           fault_code;
    logic [CYC_WIDTH-1:0] cycle_count;

    modport master (
        output start, abort, load_valid, load_data, load_last, cpu_pc,
        input  load_ready, mem_we, mem_addr, mem_wdata, reg_we, reg_addr, reg_wdata,
               cpu_reset, busy, done, fault, fault_code, cycle_count
    );

    modport slave (
        input  start, abort, load_valid, load_data, load_last, cpu_pc,
        output load_ready, mem_we, mem_addr, mem_wdata, reg_we, reg_addr, reg_wdata,
               cpu_reset, busy, done, fault, fault_code, cycle_count
    );
endinterface

// File: rtl/program_run_controller.sv
// Loads a program image, seeds SP/LR, runs the core until PC hits LR or the cycle budget expires.
// All outputs registered; image words are written one cycle after handshake, one word per cycle max.
module program_run_controller #(
    parameter int          ADDR_WIDTH = 20,
    parameter logic [31:0] SP_INIT    = 32'h003F_FFFC,
    parameter int          MAX_CYCLES = 1000000,
    parameter int          CYC_WIDTH  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    program_run_controller_if.slave  bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_INIT_SP = 3'd2;
    localparam logic [2:0] S_INIT_LR = 3'd3;
    localparam logic [2:0] S_RUN     = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_FAULT   = 3'd6;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_OVERFLW = 2'd1;
    localparam logic [1:0] FC_TIMEOUT = 2'd2;

    localparam logic [31:0]           LR_INIT   = SP_INIT + 32'd4;
    localparam logic [ADDR_WIDTH-1:0] IDX_LAST  = '1;
    localparam logic [CYC_WIDTH-1:0]  CYC_LIMIT = CYC_WIDTH'(MAX_CYCLES - 1);
    localparam logic [CYC_WIDTH-1:0]  CYC_SAT   = '1;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] index_q, index_d;
    logic                  load_ready_q, load_ready_d;
    logic                  mem_we_q, mem_we_d;
    logic [31:0]           mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  reg_we_q, reg_we_d;
    logic [3:0]            reg_addr_q, reg_addr_d;
    logic [31:0]           reg_wdata_q, reg_wdata_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  fault_q, fault_d;
    logic [1:0]            fault_code_q, fault_code_d;
    logic [CYC_WIDTH-1:0]  cycle_q, cycle_d;
    logic                  xfer;

    assign xfer = (state_q == S_LOAD) && bus.load_valid && load_ready_q;

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        load_ready_d = load_ready_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        reg_we_d     = 1'b0;
        reg_addr_d   = reg_addr_q;
        reg_wdata_d  = reg_wdata_q;
        cpu_reset_d  = cpu_reset_q;
        done_d       = done_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        cycle_d      = cycle_q;

        // Abort overrides start and drops any write that would have been issued this cycle.
        if (bus.abort) begin
            state_d      = S_IDLE;
            load_ready_d = 1'b0;
            cpu_reset_d  = 1'b1;
            done_d       = 1'b0;
            fault_d      = 1'b0;
            fault_code_d = FC_NONE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_FAULT: begin
                    if (bus.start) begin
                        state_d      = S_LOAD;
                        index_d      = '0;
                        load_ready_d = 1'b1;
                        cpu_reset_d  = 1'b1;
                        done_d       = 1'b0;
                        fault_d      = 1'b0;
                        fault_code_d = FC_NONE;
                        cycle_d      = '0;
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = 32'({index_q, 2'b00});
                        mem_wdata_d = bus.load_data;
                        index_d     = index_q + ADDR_WIDTH'(1);
                        if (bus.load_last) begin
                            state_d      = S_INIT_SP;
                            load_ready_d = 1'b0;
                            reg_we_d     = 1'b1;
                            reg_addr_d   = 4'd13;
                            reg_wdata_d  = SP_INIT;
                        end else if (index_q == IDX_LAST) begin
                            state_d      = S_FAULT;
                            load_ready_d = 1'b0;
                            fault_d      = 1'b1;
                            fault_code_d = FC_OVERFLW;
                        end
                    end
                end
                S_INIT_SP: begin
                    state_d     = S_INIT_LR;
                    reg_we_d    = 1'b1;
                    reg_addr_d  = 4'd14;
                    reg_wdata_d = LR_INIT;
                end
                S_INIT_LR: begin
                    state_d     = S_RUN;
                    cpu_reset_d = 1'b0;
                end
                S_RUN: begin
                    if (cycle_q != CYC_SAT) begin
                        cycle_d = cycle_q + CYC_WIDTH'(1);
                    end
                    // A halt seen on the budget's last cycle still counts as a clean finish.
                    if (bus.cpu_pc == LR_INIT) begin
                        state_d     = S_DONE;
                        done_d      = 1'b1;
                        cpu_reset_d = 1'b1;
                    end else if (cycle_q == CYC_LIMIT) begin
                        state_d      = S_FAULT;
                        fault_d      = 1'b1;
                        fault_code_d = FC_TIMEOUT;
                        cpu_reset_d  = 1'b1;
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    cpu_reset_d = 1'b1;
                end
            endcase
        end

        busy_d = (state_d == S_LOAD) || (state_d == S_INIT_SP) ||
                 (state_d == S_INIT_LR) || (state_d == S_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            index_q      <= '0;
            load_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            reg_we_q     <= 1'b0;
            reg_addr_q   <= '0;
            reg_wdata_q  <= '0;
            cpu_reset_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
            cycle_q      <= '0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            load_ready_q <= load_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            reg_we_q     <= reg_we_d;
            reg_addr_q   <= reg_addr_d;
            reg_wdata_q  <= reg_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            cycle_q      <= cycle_d;
        end
    end

    assign bus.load_ready  = load_ready_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.reg_we      = reg_we_q;
    assign bus.reg_addr    = reg_addr_q;
    assign bus.reg_wdata   = reg_wdata_q;
    assign bus.cpu_reset   = cpu_reset_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.fault       = fault_q;
    assign bus.fault_code  = fault_code_q;
    assign bus.cycle_count = cycle_q;
endmodule
